pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
- Parametrised pipeline sequencing block for the MIPS core. It replaces the fixed always-enabled pipeline register enables with computed per-register enables, flushes and valid bits.
- It arbitrates instruction-fetch waits, data-memory waits, load-use hazards, taken branches/jumps and halt retirement.
- It sits beside control_unit in the datapath. It drives pc_en, every pipeline register enable/flush, and dpif.halt.

Parameters:
- NREG, 4, number of pipeline registers (0=IF/ID, 1=ID/EX, NREG-2=EX/MEM, NREG-1=MEM/WB); legal range 4..8.
- REGSEL_W, 5, register-select width.
- CNT_W, 32, performance counter width.

Ports:
- CLK  in  1  clock.
- nRST  in  1  synchronous active-low reset.
- ihit  in  1  instruction memory returned imemload this cycle.
- dhit  in  1  data memory completed this cycle.
- dmem_req  in  1  instruction in EX/MEM is issuing dmemREN or dmemWEN.
- id_rs  in  REGSEL_W  rs of the instruction in IF/ID.
- id_rt  in  REGSEL_W  rt of the instruction in IF/ID.
- ex_memread  in  1  instruction in ID/EX is a load.
- ex_wsel  in  REGSEL_W  destination of the instruction in ID/EX.
- ex_redirect  in  1  instruction in ID/EX is a taken branch/jump.
- wb_halt  in  1  instruction in MEM/WB is halt or an overflow trap.
- pc_en  out  1  PC register load enable.
- reg_en  out  NREG  per-register load enable.
- reg_flush  out  NREG  per-register clear-to-bubble; overrides reg_en.
- reg_valid  out  NREG  registered valid bit per pipeline register.
- halt  out  1  sticky halt to dpif.halt.
- stall_cnt  out  CNT_W  stall-cycle counter.
- flush_cnt  out  CNT_W  flush-event counter.
- retire_cnt  out  CNT_W  retired-instruction counter.

Behaviour:
- Clock and reset: single clock CLK; reset nRST is synchronous, active-low. All state updates on the CLK rising edge.
- Reset: reg_valid=0, halt=0, all counters 0. While nRST=0 the combinational outputs are held at pc_en=0, reg_en=0, reg_flush=all 1s.
- Derived conditions (combinational, valid-qualified):
  - mem_wait = reg_valid[NREG-2] & dmem_req & ~dhit.
  - load_use = reg_valid[1] & reg_valid[0] & ex_memread & (ex_wsel!=0) & (ex_wsel==id_rs | ex_wsel==id_rt).
  - redirect = reg_valid[1] & ex_redirect.
  - hlt = halt | (reg_valid[NREG-1] & wb_halt).
- Priority, highest first; exactly one case applies per cycle:
  - HALTED (hlt): pc_en=0, reg_en=0, reg_flush=0. Pipeline frozen.
  - MEMWAIT (mem_wait): pc_en=0, reg_en=0, except reg_en[NREG-1]=0 with reg_flush[NREG-1]=1 (bubble into WB so the stalled memory instruction does not double-write).
  - LOADUSE (load_use, no mem_wait): pc_en=0, reg_en[0]=0, reg_flush[1]=1, reg_en[k>=2]=1.
  - REDIRECT (redirect): pc_en=1 regardless of ihit, reg_flush[0]=1, reg_flush[1]=1, reg_en[k>=2]=1.
  - FETCHWAIT (~ihit): pc_en=0, reg_flush[0]=1, reg_en[k>=1]=1.
  - RUN: pc_en=1, reg_en=all 1s.
- Valid update: if reg_flush[k], reg_valid[k]<=0. Else if reg_en[k], reg_valid[k]<=(k==0 ? 1 : reg_valid[k-1]). Otherwise hold.
- Halt:
  - halt<=1 the cycle after MEM/WB holds a valid wb_halt.
  - Sticky until reset; later ihit/dhit are ignored.
  - Reset asserted while halted clears everything in one edge.
- Simultaneous events:
  - load_use and redirect cannot both be true (same ID/EX instruction); if both arrive, load_use wins.
  - mem_wait together with redirect: the redirect is deferred (held in ID/EX) until dhit.
- Latency: zero-cycle combinational enables; one-cycle registered valid/halt.

Optional Feature:
- Macro PIPELINE_CTRL_PERF_EN.
- Defined:
  - stall_cnt increments on every MEMWAIT, LOADUSE or FETCHWAIT cycle.
  - flush_cnt increments on each REDIRECT cycle.
  - retire_cnt increments when reg_valid[NREG-1] & reg_en[NREG-1] & ~hlt.
  - All counters wrap modulo 2^CNT_W and freeze when halted.
- Undefined: the three ports remain and are tied to 0; no counter flops are synthesised.

Decomposition:
- cpu_types_pkg additions:
  - typedef enum pipe_case_t {RUN, FETCHWAIT, REDIRECT, LOADUSE, MEMWAIT, HALTED}.
  - localparams IFID_IDX=0 and IDEX_IDX=1.
- One natural sub-module, hazard_detect: purely combinational load_use compare. It is reused later by a forwarding unit.

Test Plan:
- Reset, then ihit=1 with no hazards for 6 cycles: reg_valid goes 0001→0011→0111→1111, pc_en=1 every cycle, halt=0.
- id_rs=5, ex_wsel=5, ex_memread=1, all valid: one cycle with pc_en=0, reg_en[0]=0, reg_flush[1]=1. Next cycle reg_valid[1]=0. With PERF enabled, stall_cnt=1.
- ex_redirect=1 with ihit=0: pc_en=1, reg_flush=0011. Next cycle reg_valid[1:0]=00, flush_cnt=1.
- dmem_req=1, dhit=0 for 3 cycles, then dhit=1: reg_en=0 and pc_en=0 for 3 cycles, reg_flush[3]=1; normal advance on the dhit cycle, stall_cnt=3.
- wb_halt=1 with reg_valid[3]=1: halt=1 the next cycle and stays 1 across 10 cycles of toggling ihit/dhit. Asserting nRST=0 clears halt on the next edge.
- ex_wsel=0 with ex_memread=1 and id_rs=0: no load-use stall, pc_en=1.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline sequencing logic: the per-cycle sequencing
// case, the fixed indices of the front pipeline registers, and a helper
// that classifies which cases count as stall cycles.
package pipeline_ctrl_pkg;

  typedef enum logic [2:0] {
    RUN       = 3'd0,
    FETCHWAIT = 3'd1,
    REDIRECT  = 3'd2,
    LOADUSE   = 3'd3,
    MEMWAIT   = 3'd4,
    HALTED    = 3'd5
  } pipe_case_t;

  localparam int IFID_IDX = 0;
  localparam int IDEX_IDX = 1;

  // Cycles in which the PC is held because something upstream must wait.
  function automatic logic is_stall_case(input pipe_case_t c);
    logic r;
    case (c)
      MEMWAIT, LOADUSE, FETCHWAIT: r = 1'b1;
      default:                     r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard.sv
// Load-use hazard compare between the load in ID/EX and the consumer in
// IF/ID. Purely combinational so a forwarding unit can reuse it.
module hazard_detect #(
  parameter int REGSEL_W = 5
) (
  input  logic                ex_valid,
  input  logic                id_valid,
  input  logic                ex_memread,
  input  logic [REGSEL_W-1:0] ex_wsel,
  input  logic [REGSEL_W-1:0] id_rs,
  input  logic [REGSEL_W-1:0] id_rt,
  output logic                load_use
);

  logic wsel_nonzero_s;
  logic wsel_match_s;

  // Register 0 is never a real dependency, so a load targeting it never stalls.
  always_comb begin
    wsel_nonzero_s = (ex_wsel != {REGSEL_W{1'b0}});
    wsel_match_s   = (ex_wsel == id_rs) | (ex_wsel == id_rt);
    load_use       = ex_valid & id_valid & ex_memread & wsel_nonzero_s & wsel_match_s;
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencing for the MIPS core: computes PC enable, per-register
// enables/flushes, registered valid bits and the sticky halt.
// Optional performance counters are built when PIPELINE_CTRL_PERF_EN is
// defined; otherwise the counter ports are tied to zero.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int NREG     = 4,
  parameter int REGSEL_W = 5,
  parameter int CNT_W    = 32
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic                ihit,
  input  logic                dhit,
  input  logic                dmem_req,
  input  logic [REGSEL_W-1:0] id_rs,
  input  logic [REGSEL_W-1:0] id_rt,
  input  logic                ex_memread,
  input  logic [REGSEL_W-1:0] ex_wsel,
  input  logic                ex_redirect,
  input  logic                wb_halt,
  output logic                pc_en,
  output logic [NREG-1:0]     reg_en,
  output logic [NREG-1:0]     reg_flush,
  output logic [NREG-1:0]     reg_valid,
  output logic                halt,
  output logic [CNT_W-1:0]    stall_cnt,
  output logic [CNT_W-1:0]    flush_cnt,
  output logic [CNT_W-1:0]    retire_cnt
);

  logic [NREG-1:0] reg_valid_r;
  logic [NREG-1:0] valid_next_s;
  logic            halt_r;
  logic            load_use_s;
  logic            mem_wait_s;
  logic            redirect_s;
  logic            hlt_s;
  pipe_case_t      case_s;

  hazard_detect #(.REGSEL_W(REGSEL_W)) u_hazard_detect (
    .ex_valid   (reg_valid_r[IDEX_IDX]),
    .id_valid   (reg_valid_r[IFID_IDX]),
    .ex_memread (ex_memread),
    .ex_wsel    (ex_wsel),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .load_use   (load_use_s)
  );

  // Valid-qualified hazard conditions and the single winning case this cycle.
  always_comb begin
    mem_wait_s = reg_valid_r[NREG-2] & dmem_req & ~dhit;
    redirect_s = reg_valid_r[IDEX_IDX] & ex_redirect;
    hlt_s      = halt_r | (reg_valid_r[NREG-1] & wb_halt);
    if (hlt_s) begin
      case_s = HALTED;
    end else if (mem_wait_s) begin
      case_s = MEMWAIT;
    end else if (load_use_s) begin
      case_s = LOADUSE;
    end else if (redirect_s) begin
      case_s = REDIRECT;
    end else if (!ihit) begin
      case_s = FETCHWAIT;
    end else begin
      case_s = RUN;
    end
  end

  // Enables and flushes per case; reset forces every register to a bubble.
  always_comb begin
    pc_en     = 1'b0;
    reg_en    = {NREG{1'b0}};
    reg_flush = {NREG{1'b0}};
    if (!nRST) begin
      reg_flush = {NREG{1'b1}};
    end else begin
      case (case_s)
        HALTED: begin
          reg_en = {NREG{1'b0}};
        end
        MEMWAIT: begin
          reg_flush[NREG-1] = 1'b1;
        end
        LOADUSE: begin
          reg_en              = {{(NREG-2){1'b1}}, 2'b00};
          reg_flush[IDEX_IDX] = 1'b1;
        end
        REDIRECT: begin
          pc_en               = 1'b1;
          reg_en              = {{(NREG-2){1'b1}}, 2'b00};
          reg_flush[IFID_IDX] = 1'b1;
          reg_flush[IDEX_IDX] = 1'b1;
        end
        FETCHWAIT: begin
          reg_en              = {{(NREG-1){1'b1}}, 1'b0};
          reg_flush[IFID_IDX] = 1'b1;
        end
        RUN: begin
          pc_en  = 1'b1;
          reg_en = {NREG{1'b1}};
        end
        default: begin
          pc_en  = 1'b0;
        end
      endcase
    end
  end

  // Next valid bits: flush clears, enable shifts the upstream valid in, else hold.
  always_comb begin
    valid_next_s = reg_valid_r;
    if (reg_flush[0]) begin
      valid_next_s[0] = 1'b0;
    end else if (reg_en[0]) begin
      valid_next_s[0] = 1'b1;
    end else begin
      valid_next_s[0] = reg_valid_r[0];
    end
    for (int k = 1; k < NREG; k++) begin
      if (reg_flush[k]) begin
        valid_next_s[k] = 1'b0;
      end else if (reg_en[k]) begin
        valid_next_s[k] = reg_valid_r[k-1];
      end else begin
        valid_next_s[k] = reg_valid_r[k];
      end
    end
  end

  // Valid bits and sticky halt; halt latches once a valid halt sits in MEM/WB.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      reg_valid_r <= {NREG{1'b0}};
      halt_r      <= 1'b0;
    end else begin
      reg_valid_r <= valid_next_s;
      halt_r      <= halt_r | (reg_valid_r[NREG-1] & wb_halt);
    end
  end

  assign reg_valid = reg_valid_r;
  assign halt      = halt_r;

`ifdef PIPELINE_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;
  logic [CNT_W-1:0] retire_cnt_r;

  // Performance counters; they wrap naturally and stop while halted.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      stall_cnt_r  <= {CNT_W{1'b0}};
      flush_cnt_r  <= {CNT_W{1'b0}};
      retire_cnt_r <= {CNT_W{1'b0}};
    end else if (!hlt_s) begin
      if (is_stall_case(case_s)) begin
        stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (case_s == REDIRECT) begin
        flush_cnt_r <= flush_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
      if (reg_valid_r[NREG-1] & reg_en[NREG-1]) begin
        retire_cnt_r <= retire_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        retire_cnt_r <= retire_cnt_r;
      end
    end else begin
      stall_cnt_r  <= stall_cnt_r;
      flush_cnt_r  <= flush_cnt_r;
      retire_cnt_r <= retire_cnt_r;
    end
  end

  assign stall_cnt  = stall_cnt_r;
  assign flush_cnt  = flush_cnt_r;
  assign retire_cnt = retire_cnt_r;
`else
  assign stall_cnt  = {CNT_W{1'b0}};
  assign flush_cnt  = {CNT_W{1'b0}};
  assign retire_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed scenarios followed by random
// traffic, predicted by a rule-table reference model and checked by an
// independent monitor on the falling clock edge.
module tb_pipeline_ctrl;

  localparam int NREG = 4;
  localparam int RW   = 5;
  localparam int CW   = 32;

  localparam int M_RESET = 0, M_HALTED = 1, M_MEMWAIT = 2, M_LOADUSE = 3,
                 M_REDIRECT = 4, M_FETCHWAIT = 5, M_RUN = 6;

  logic          CLK = 1'b0;
  logic          nRST;
  logic          ihit, dhit, dmem_req, ex_memread, ex_redirect, wb_halt;
  logic [RW-1:0] id_rs, id_rt, ex_wsel;
  logic          pc_en, halt;
  logic [NREG-1:0] reg_en, reg_flush, reg_valid;
  logic [CW-1:0] stall_cnt, flush_cnt, retire_cnt;

  pipeline_ctrl #(.NREG(NREG), .REGSEL_W(RW), .CNT_W(CW)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .dmem_req(dmem_req),
    .id_rs(id_rs), .id_rt(id_rt), .ex_memread(ex_memread), .ex_wsel(ex_wsel),
    .ex_redirect(ex_redirect), .wb_halt(wb_halt), .pc_en(pc_en),
    .reg_en(reg_en), .reg_flush(reg_flush), .reg_valid(reg_valid),
    .halt(halt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
    .retire_cnt(retire_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic            pc;
    logic [NREG-1:0] en;
    logic [NREG-1:0] fl;
    logic [NREG-1:0] vld;
    logic            hlt;
    logic [CW-1:0]   sc;
    logic [CW-1:0]   fc;
    logic [CW-1:0]   rc;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: what the pipeline should hold between edges.
  logic [NREG-1:0] m_valid;
  logic            m_halt;
  logic [CW-1:0]   m_stall, m_flush, m_retire;

  task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Predict this cycle's outputs from the current inputs, queue them, then
  // advance the model across the coming rising edge.
  task automatic step();
    exp_t e;
    int   mode;
    logic mw, lu, rd, hl;
    logic [NREG-1:0] nv;
    mw = m_valid[NREG-2] && dmem_req && !dhit;
    lu = m_valid[1] && m_valid[0] && ex_memread && (ex_wsel != 0) &&
         ((ex_wsel == id_rs) || (ex_wsel == id_rt));
    rd = m_valid[1] && ex_redirect;
    hl = m_halt || (m_valid[NREG-1] && wb_halt);
    if (!nRST)      mode = M_RESET;
    else if (hl)    mode = M_HALTED;
    else if (mw)    mode = M_MEMWAIT;
    else if (lu)    mode = M_LOADUSE;
    else if (rd)    mode = M_REDIRECT;
    else if (!ihit) mode = M_FETCHWAIT;
    else            mode = M_RUN;

    e.pc = (mode == M_RUN) || (mode == M_REDIRECT);
    for (int k = 0; k < NREG; k++) begin
      e.en[k] = (mode == M_RUN) ||
                ((mode == M_LOADUSE || mode == M_REDIRECT) && k >= 2) ||
                (mode == M_FETCHWAIT && k >= 1);
      e.fl[k] = (mode == M_RESET) ||
                (mode == M_MEMWAIT && k == NREG-1) ||
                (mode == M_LOADUSE && k == 1) ||
                (mode == M_REDIRECT && k <= 1) ||
                (mode == M_FETCHWAIT && k == 0);
    end
    e.vld = m_valid;
    e.hlt = m_halt;
    e.sc  = m_stall;
    e.fc  = m_flush;
    e.rc  = m_retire;
    sb_q.push_back(e);

    if (mode == M_RESET) begin
      m_valid  = '0;
      m_halt   = 1'b0;
      m_stall  = '0;
      m_flush  = '0;
      m_retire = '0;
    end else begin
      for (int k = 0; k < NREG; k++) begin
        if (e.fl[k])      nv[k] = 1'b0;
        else if (e.en[k]) nv[k] = (k == 0) ? 1'b1 : m_valid[k-1];
        else              nv[k] = m_valid[k];
      end
`ifdef PIPELINE_CTRL_PERF_EN
      if (mode == M_MEMWAIT || mode == M_LOADUSE || mode == M_FETCHWAIT) m_stall = m_stall + 1;
      if (mode == M_REDIRECT) m_flush = m_flush + 1;
      if (m_valid[NREG-1] && e.en[NREG-1] && !hl) m_retire = m_retire + 1;
`endif
      m_halt  = m_halt || (m_valid[NREG-1] && wb_halt);
      m_valid = nv;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic set_idle();
    ihit = 1'b1; dhit = 1'b0; dmem_req = 1'b0; ex_memread = 1'b0;
    ex_redirect = 1'b0; wb_halt = 1'b0;
    id_rs = 5'd1; id_rt = 5'd2; ex_wsel = 5'd3;
  endtask

  // Monitor: every falling edge, compare DUT outputs against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("pc_en",      {31'd0, pc_en},          {31'd0, e.pc});
        chk("reg_en",     {28'd0, reg_en},         {28'd0, e.en});
        chk("reg_flush",  {28'd0, reg_flush},      {28'd0, e.fl});
        chk("reg_valid",  {28'd0, reg_valid},      {28'd0, e.vld});
        chk("halt",       {31'd0, halt},           {31'd0, e.hlt});
        chk("stall_cnt",  stall_cnt,  e.sc);
        chk("flush_cnt",  flush_cnt,  e.fc);
        chk("retire_cnt", retire_cnt, e.rc);
      end
    end
  end

  // Driver: directed scenarios then randomized traffic.
  initial begin
    nRST = 1'b0;
    set_idle();
    repeat (2) @(posedge CLK);
    #1;
    m_valid = '0; m_halt = 1'b0; m_stall = '0; m_flush = '0; m_retire = '0;

    step();                       // reset state observed
    nRST = 1'b1;
    repeat (6) step();            // fill the pipeline

    id_rs = 5'd5; ex_wsel = 5'd5; ex_memread = 1'b1;
    step();                       // load-use
    set_idle();
    repeat (2) step();

    ex_redirect = 1'b1; ihit = 1'b0;
    step();                       // redirect beats fetch wait
    set_idle();
    repeat (4) step();

    dmem_req = 1'b1; dhit = 1'b0;
    repeat (3) step();            // memory wait
    dhit = 1'b1;
    step();
    set_idle();
    repeat (2) step();

    ex_wsel = 5'd0; id_rs = 5'd0; ex_memread = 1'b1;
    step();                       // load to $0 is not a hazard
    set_idle();
    repeat (3) step();

    wb_halt = 1'b1;
    step();                       // halt retires
    wb_halt = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ihit = i[0]; dhit = ~i[0]; dmem_req = 1'b1;
      step();
    end
    nRST = 1'b0;
    step();                       // reset clears halt
    nRST = 1'b1;
    set_idle();
    step();

    for (int i = 0; i < 1500; i++) begin
      nRST        = ($urandom_range(0, 39) != 0);
      ihit        = ($urandom_range(0, 3) != 0);
      dhit        = $urandom_range(0, 1) == 1;
      dmem_req    = $urandom_range(0, 1) == 1;
      id_rs       = RW'($urandom_range(0, 3));
      id_rt       = RW'($urandom_range(0, 3));
      ex_wsel     = RW'($urandom_range(0, 3));
      ex_memread  = ($urandom_range(0, 2) == 0);
      ex_redirect = ($urandom_range(0, 5) == 0);
      wb_halt     = ($urandom_range(0, 79) == 0);
      step();
    end

    @(negedge CLK);
    @(posedge CLK);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
